// File: rtl/multi_channel_scan_mux_pkg.sv
// Shared types and constants for the multi-channel scan multiplexer.
// Latency: n/a (declarations only).
// Backpressure: none; the mux is a free-running registered path.
package mux_scan_pkg;

  // Operating state applied at each clock edge, derived from E and MODE.
  typedef enum logic [1:0] {
    ST_DIS  = 2'd0,
    ST_MAN  = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  // Encoding of the MODE input.
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/multi_channel_scan_mux_scan_counter.sv
// Dwell counter plus wrapping channel counter with load, hold/clear and a step pulse.
// Latency: registered, 1 cycle; ch_nxt_o is the combinational next channel.
// Backpressure: none; load takes priority over scan, otherwise channel holds and dwell clears.
module scan_counter #(
  parameter  int NCH   = 4,
  parameter  int DWELL = 8,
  localparam int SW    = $clog2(NCH),
  localparam int DW    = $clog2(DWELL) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [SW-1:0] load_ch_i,
  input  logic          scan_i,
  input  logic          restart_i,
  output logic [SW-1:0] ch_o,
  output logic [SW-1:0] ch_nxt_o,
  output logic          step_o
);

  logic [DW-1:0] dwell_q, dwell_d, dwell_cur;
  logic [SW-1:0] ch_q, ch_d;
  logic          step_q, step_d;

  // Next channel / dwell / step; a fresh scan entry always counts from dwell zero.
  always_comb begin
    dwell_cur = restart_i ? '0 : dwell_q;
    dwell_d   = '0;
    ch_d      = ch_q;
    step_d    = 1'b0;
    if (load_i) begin
      ch_d   = load_ch_i;
      step_d = (load_ch_i != ch_q);
    end else if (scan_i) begin
      if (dwell_cur == DW'(DWELL - 1)) begin
        ch_d   = (ch_q == SW'(NCH - 1)) ? '0 : ch_q + 1'b1;
        step_d = 1'b1;
      end else begin
        dwell_d = dwell_cur + 1'b1;
      end
    end
  end

  // Counter state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dwell_q <= '0;
      ch_q    <= '0;
      step_q  <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      ch_q    <= ch_d;
      step_q  <= step_d;
    end
  end

  assign ch_o     = ch_q;
  assign ch_nxt_o = ch_d;
  assign step_o   = step_q;

endmodule

// File: rtl/multi_channel_scan_mux.sv
// Registered N-channel x W-bit mux with active-low enable, manual select and auto-scan.
// Latency: 1 cycle from inputs to Y/CH/VALID/STEP.
// Backpressure: none; E=1 forces Y/VALID low while CH holds.
module multi_channel_scan_mux #(
  parameter  int WIDTH = 4,
  parameter  int NCH   = 4,
  parameter  int DWELL = 8,
  localparam int SW    = $clog2(NCH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH*WIDTH-1:0] D,
  input  logic [SW-1:0]        S,
  input  logic                 MODE,
  input  logic                 E,
  output logic [WIDTH-1:0]     Y,
  output logic [SW-1:0]        CH,
  output logic                 VALID,
  output logic                 STEP
);
  import mux_scan_pkg::*;

  state_t           st_q, st_d;
  logic             s_ok, load, scan, restart, valid_d;
  logic [SW-1:0]    ch_nxt;
  logic [WIDTH-1:0] sel, y_d, y_q;
  logic             valid_q;

  // Next state and per-edge control decode; S beyond NCH-1 is treated as no channel.
  always_comb begin
    st_d = ST_SCAN;
    if (E) begin
      st_d = ST_DIS;
    end else if (MODE == MODE_MANUAL) begin
      st_d = ST_MAN;
    end
    s_ok    = ({1'b0, S} < (SW + 1)'(NCH));
    load    = (st_d == ST_MAN) && s_ok;
    scan    = (st_d == ST_SCAN);
    restart = (st_q != ST_SCAN);
    valid_d = load || scan;
  end

  scan_counter #(
    .NCH   (NCH),
    .DWELL (DWELL)
  ) u_cnt (
    .clk_i     (CLK),
    .rst_i     (RST),
    .load_i    (load),
    .load_ch_i (S),
    .scan_i    (scan),
    .restart_i (restart),
    .ch_o      (CH),
    .ch_nxt_o  (ch_nxt),
    .step_o    (STEP)
  );

  // Data follows the next channel so Y always matches CH after the edge.
  always_comb begin
    sel = D[int'(ch_nxt)*WIDTH +: WIDTH];
    y_d = valid_d ? sel : '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q    <= ST_DIS;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign Y     = y_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_multi_channel_scan_mux.sv
// Directed self-checking bench for multi_channel_scan_mux (NCH=4, NCH=3, DWELL=1 variants).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_multi_channel_scan_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: NCH=4, WIDTH=4, DWELL=8
  logic        rst, e, mode;
  logic [15:0] d;
  logic [1:0]  s;
  logic [3:0]  y;
  logic [1:0]  ch;
  logic        valid, step;

  // NCH=3 instance
  logic        rst3, e3, mode3;
  logic [11:0] d3;
  logic [1:0]  s3;
  logic [3:0]  y3;
  logic [1:0]  ch3;
  logic        valid3, step3;

  // DWELL=1 instance
  logic        rst1, e1, mode1;
  logic [1:0]  s1;
  logic [3:0]  y1;
  logic [1:0]  ch1;
  logic        valid1, step1;

  int n_chk  = 0;
  int n_pass = 0;

  multi_channel_scan_mux #(.WIDTH(4), .NCH(4), .DWELL(8)) dut (
    .CLK(clk), .RST(rst), .D(d), .S(s), .MODE(mode), .E(e),
    .Y(y), .CH(ch), .VALID(valid), .STEP(step)
  );

  multi_channel_scan_mux #(.WIDTH(4), .NCH(3), .DWELL(8)) dut3 (
    .CLK(clk), .RST(rst3), .D(d3), .S(s3), .MODE(mode3), .E(e3),
    .Y(y3), .CH(ch3), .VALID(valid3), .STEP(step3)
  );

  multi_channel_scan_mux #(.WIDTH(4), .NCH(4), .DWELL(1)) dut1 (
    .CLK(clk), .RST(rst1), .D(d), .S(s1), .MODE(mode1), .E(e1),
    .Y(y1), .CH(ch1), .VALID(valid1), .STEP(step1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] chan(input logic [15:0] v, input int k);
    logic [15:0] t;
    t = v;
    return t[k*4 +: 4];
  endfunction

  // Checks all four outputs of the main instance.
  task automatic check_main(input string tag, input logic [3:0] ey, input logic [1:0] ech,
                            input logic ev, input logic es);
    check({tag, ".Y"},     32'(y),     32'(ey));
    check({tag, ".CH"},    32'(ch),    32'(ech));
    check({tag, ".VALID"}, 32'(valid), 32'(ev));
    check({tag, ".STEP"},  32'(step),  32'(es));
  endtask

  initial begin
    int exp_ch;
    // Reset everything with all-ones data present
    rst = 1'b1; e = 1'b1; mode = 1'b0; s = 2'd0; d = 16'hFFFF;
    rst3 = 1'b1; e3 = 1'b1; mode3 = 1'b0; s3 = 2'd0; d3 = 12'h7B2;
    rst1 = 1'b1; e1 = 1'b0; mode1 = 1'b1; s1 = 2'd0;
    tick();
    tick();
    check_main("reset", 4'h0, 2'd0, 1'b0, 1'b0);
    check("reset3.VALID", 32'(valid3), 32'd0);
    check("reset1.CH", 32'(ch1), 32'd0);

    // Manual select of channel 2; channels: 0=C 1=5 2=A 3=3
    d = 16'h3A5C;
    rst = 1'b0; e = 1'b0; mode = 1'b0; s = 2'd2;
    tick();
    check_main("man_s2", 4'hA, 2'd2, 1'b1, 1'b1);
    tick();
    check_main("man_s2_hold", 4'hA, 2'd2, 1'b1, 1'b0);

    // Disable, then re-enable
    e = 1'b1;
    tick();
    check_main("dis", 4'h0, 2'd2, 1'b0, 1'b0);
    e = 1'b0;
    tick();
    check_main("reen", 4'hA, 2'd2, 1'b1, 1'b0);

    // Move to channel 3, then auto-scan a full round
    s = 2'd3;
    tick();
    check_main("man_s3", 4'h3, 2'd3, 1'b1, 1'b1);
    mode = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      tick();
      exp_ch = (3 + c / 8) % 4;
      check_main($sformatf("scan_c%0d", c), chan(d, exp_ch), 2'(exp_ch), 1'b1, (c % 8) == 0);
    end

    // Reset at dwell=5 mid-scan; back at CH=3 after the full round
    for (int c = 1; c <= 5; c++) tick();
    check("pre_rst.CH", 32'(ch), 32'd3);
    rst = 1'b1;
    tick();
    check_main("mid_rst", 4'h0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c < 8) check_main($sformatf("post_rst_c%0d", c), 4'hC, 2'd0, 1'b1, 1'b0);
      else       check_main("post_rst_step", 4'h5, 2'd1, 1'b1, 1'b1);
    end

    // Scan -> manual: S applies at the next edge
    mode = 1'b0; s = 2'd2;
    tick();
    check_main("scan_to_man", 4'hA, 2'd2, 1'b1, 1'b1);

    // NCH=3: channels 0=2 1=B 2=7; S=3 is out of range
    rst3 = 1'b0; e3 = 1'b0; mode3 = 1'b0; s3 = 2'd2;
    tick();
    check("n3_s2.Y", 32'(y3), 32'h7);
    check("n3_s2.CH", 32'(ch3), 32'd2);
    s3 = 2'd3;
    tick();
    check("n3_s3.Y", 32'(y3), 32'h0);
    check("n3_s3.VALID", 32'(valid3), 32'd0);
    check("n3_s3.CH", 32'(ch3), 32'd2);
    check("n3_s3.STEP", 32'(step3), 32'd0);
    s3 = 2'd1;
    tick();
    check("n3_s1.Y", 32'(y3), 32'hB);
    check("n3_s1.VALID", 32'(valid3), 32'd1);
    check("n3_s1.CH", 32'(ch3), 32'd1);

    // DWELL=1: advances every cycle with STEP held high
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("dw1_c%0d.CH", c), 32'(ch1), 32'(c % 4));
      check($sformatf("dw1_c%0d.STEP", c), 32'(step1), 32'd1);
      check($sformatf("dw1_c%0d.Y", c), 32'(y1), 32'(chan(d, c % 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
